// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcodes, funct3 codes and ALU/writeback selectors for riscv_top
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_t;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wb_sel_t;

  // alt selects SUB for ADD and SRA for SRL; callers decide when alt is meaningful
  function automatic alu_op_t alu_from_f3(logic [2:0] f3, logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SRL:  return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/riscv_alu.sv
// rtl/riscv_alu.sv - 32-bit RV32I integer ALU
import riscv_pkg::*;

module riscv_alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_SLL:   y = a << b[4:0];
      ALU_SLT:   y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:  y = {31'b0, a < b};
      ALU_XOR:   y = a ^ b;
      ALU_SRL:   y = a >> b[4:0];
      ALU_SRA:   y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:    y = a | b;
      ALU_AND:   y = a & b;
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/riscv_top.sv
// rtl/riscv_top.sv - single-cycle RV32I core with internal instruction ROM and data RAM
import riscv_pkg::*;

module riscv_top #(
  parameter int    IMEM_WORDS = 1024,
  parameter int    DMEM_WORDS = 1024,
  parameter string IMEM_INIT  = "program.hex"
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [15:0] ADDR
);

  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_WORDS);

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS] = '{default: '0};
  logic [31:0] regs [32];

  logic [31:0] pc, pc_plus4, next_pc, inst;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1v, rs2v, alu_a, alu_b, alu_y, wb_val;
  logic [31:0] rword, load_val, store_data;
  logic [3:0]  store_be;
  logic        reg_we, mem_we, br_taken;
  alu_op_t     alu_op;
  wb_sel_t     wb_sel;

  assign inst     = imem[pc[IA+1:2]];
  assign pc_plus4 = pc + 32'd4;
  assign ADDR     = pc[15:0];

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Same-cycle writes land at the edge, so reads always see the pre-edge value
  assign rs1v = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2v = (rs2 == 5'd0) ? '0 : regs[rs2];

  always_comb begin
    br_taken = 1'b0;
    case (f3)
      F3_BEQ:  br_taken = (rs1v == rs2v);
      F3_BNE:  br_taken = (rs1v != rs2v);
      F3_BLT:  br_taken = ($signed(rs1v) < $signed(rs2v));
      F3_BGE:  br_taken = ($signed(rs1v) >= $signed(rs2v));
      F3_BLTU: br_taken = (rs1v < rs2v);
      F3_BGEU: br_taken = (rs1v >= rs2v);
      default: br_taken = 1'b0;
    endcase
  end

  // Default ALU setup (rs1 + immI) already serves loads and the JALR target
  always_comb begin
    alu_op  = ALU_ADD;
    alu_a   = rs1v;
    alu_b   = imm_i;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    wb_sel  = WB_ALU;
    next_pc = pc_plus4;
    case (opcode)
      OP_LUI: begin
        alu_op = ALU_PASSB;
        alu_b  = imm_u;
        reg_we = 1'b1;
      end
      OP_AUIPC: begin
        alu_a  = pc;
        alu_b  = imm_u;
        reg_we = 1'b1;
      end
      OP_JAL: begin
        reg_we  = 1'b1;
        wb_sel  = WB_LINK;
        next_pc = pc + imm_j;
      end
      OP_JALR: begin
        reg_we  = 1'b1;
        wb_sel  = WB_LINK;
        next_pc = {alu_y[31:1], 1'b0};
      end
      OP_BRANCH: begin
        if (br_taken) next_pc = pc + imm_b;
      end
      OP_LOAD: begin
        reg_we = 1'b1;
        wb_sel = WB_MEM;
      end
      OP_STORE: begin
        alu_b  = imm_s;
        mem_we = 1'b1;
      end
      OP_IMM: begin
        alu_op = alu_from_f3(f3, (f3 == F3_SRL) && inst[30]);
        reg_we = 1'b1;
      end
      OP_OP: begin
        alu_op = alu_from_f3(f3, inst[30]);
        alu_b  = rs2v;
        reg_we = 1'b1;
      end
      default: ;
    endcase
  end

  riscv_alu u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y)
  );

  assign rword = dmem[alu_y[DA+1:2]];

  always_comb begin
    load_val = rword;
    case (f3)
      F3_LB: load_val = {{24{rword[8*alu_y[1:0]+7]}}, rword[8*alu_y[1:0] +: 8]};
      F3_LBU: load_val = {24'b0, rword[8*alu_y[1:0] +: 8]};
      F3_LH: load_val = {{16{rword[16*alu_y[1]+15]}}, rword[16*alu_y[1] +: 16]};
      F3_LHU: load_val = {16'b0, rword[16*alu_y[1] +: 16]};
      default: load_val = rword;
    endcase
  end

  always_comb begin
    store_data = rs2v;
    store_be   = 4'b1111;
    case (f3)
      F3_SB: begin
        store_data = {4{rs2v[7:0]}};
        store_be   = 4'b0001 << alu_y[1:0];
      end
      F3_SH: begin
        store_data = {2{rs2v[15:0]}};
        store_be   = alu_y[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_val = load_val;
      WB_LINK: wb_val = pc_plus4;
      default: wb_val = alu_y;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) pc <= '0;
    else     pc <= next_pc;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (reg_we && rd != 5'd0) begin
      regs[rd] <= wb_val;
    end
  end

  // RAM is deliberately left untouched by reset
  always_ff @(posedge CLK) begin
    if (!RST && mem_we) begin
      for (int l = 0; l < 4; l++)
        if (store_be[l]) dmem[alu_y[DA+1:2]][8*l +: 8] <= store_data[8*l +: 8];
    end
  end

endmodule

// File: tb/tb_riscv_top.sv
// tb/tb_riscv_top.sv - directed scoreboard bench for riscv_top
import riscv_pkg::*;

module tb_riscv_top;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] ADDR;

  riscv_top #(.IMEM_WORDS(1024), .DMEM_WORDS(1024), .IMEM_INIT("")) dut (
    .CLK  (CLK),
    .RST  (RST),
    .ADDR (ADDR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [31:0] enc_i(int imm, int rs1, logic [2:0] f3, int rd, logic [6:0] op);
    logic [31:0] v = imm;
    return {v[11:0], 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, int rs2, int rs1, logic [2:0] f3, int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), OP_OP};
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, logic [2:0] f3);
    logic [31:0] v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), f3, v[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, logic [2:0] f3);
    logic [31:0] v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), f3, v[4:1], v[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_u(int imm20, int rd, logic [6:0] op);
    logic [31:0] v = imm20;
    return {v[19:0], 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [31:0] v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), OP_JAL};
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 1024; i++) dut.imem[i] = 32'h0000_0000;
    for (int i = 0; i < prog.size(); i++) dut.imem[i] = prog[i];
  endtask

  task automatic push(string tag, int kind, int idx, logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       obs = {16'h0000, ADDR};
        1:       obs = dut.regs[e.idx];
        default: obs = dut.dmem[e.idx];
      endcase
      n_tests++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One committed instruction: check the new fetch address and optionally one register
  task automatic run(string tag, logic [31:0] addr_exp, int ridx, logic [31:0] rexp);
    step();
    push({tag, "_addr"}, 0, 0, addr_exp);
    if (ridx >= 0) push({tag, "_reg"}, 1, ridx, rexp);
    check_all();
  endtask

  initial begin
    prog = '{
      enc_i(5, 0, F3_ADD, 1, OP_IMM),
      enc_i(-3, 0, F3_ADD, 2, OP_IMM),
      enc_r(7'h00, 2, 1, F3_ADD, 3),
      enc_r(7'h20, 2, 1, F3_ADD, 4),
      enc_r(7'h00, 1, 2, F3_SLT, 5),
      enc_r(7'h00, 1, 2, F3_SLTU, 6),
      enc_i(7, 0, F3_ADD, 0, OP_IMM),
      enc_u(32'h12345, 7, OP_LUI),
      enc_u(1, 8, OP_AUIPC),
      enc_u(32'h80000, 9, OP_LUI),
      enc_i(32'h404, 9, F3_SRL, 10, OP_IMM),
      32'h0000_0000,
      enc_i(-1, 1, F3_XOR, 11, OP_IMM),
      enc_r(7'h00, 1, 1, F3_SLL, 12),
      enc_r(7'h00, 1, 9, F3_SRL, 13),
      enc_i(1, 2, F3_SLTU, 14, OP_IMM)
    };
    load_prog();
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      push("reset_hold_addr", 0, 0, 32'h0);
      check_all();
    end
    RST = 1'b0;
    push("release_addr", 0, 0, 32'h0);
    check_all();

    run("addi_x1",   32'h04, 1, 32'h0000_0005);
    run("addi_x2",   32'h08, 2, 32'hFFFF_FFFD);
    run("add_x3",    32'h0C, 3, 32'h0000_0002);
    run("sub_x4",    32'h10, 4, 32'h0000_0008);
    run("slt_x5",    32'h14, 5, 32'h0000_0001);
    run("sltu_x6",   32'h18, 6, 32'h0000_0000);
    run("addi_x0",   32'h1C, 0, 32'h0000_0000);
    run("lui_x7",    32'h20, 7, 32'h1234_5000);
    run("auipc_x8",  32'h24, 8, 32'h0000_1020);
    run("lui_x9",    32'h28, 9, 32'h8000_0000);
    run("srai_x10",  32'h2C, 10, 32'hF800_0000);
    run("nop_x10",   32'h30, 10, 32'hF800_0000);
    push("nop_x11", 1, 11, 32'h0);
    check_all();
    run("xori_x11",  32'h34, 11, 32'hFFFF_FFFA);
    run("sll_x12",   32'h38, 12, 32'h0000_00A0);
    run("srl_x13",   32'h3C, 13, 32'h0400_0000);
    run("sltiu_x14", 32'h40, 14, 32'h0000_0000);

    RST = 1'b1;
    step();
    push("reset2_addr", 0, 0, 32'h0);
    for (int r = 1; r < 15; r++) push("reset2_reg", 1, r, 32'h0);
    check_all();
    prog = '{
      enc_u(32'h80FF8, 20, OP_LUI),
      enc_i(-255, 20, F3_ADD, 20, OP_IMM),
      enc_i(32'h100, 0, F3_ADD, 21, OP_IMM),
      enc_s(0, 20, 21, F3_SW),
      enc_b(8, 0, 1, F3_BEQ),
      enc_i(0, 1, 3'b000, 0, OP_JALR),
      enc_j(-8, 1),
      enc_i(3, 21, F3_LB, 2, OP_LOAD),
      enc_i(3, 21, F3_LBU, 3, OP_LOAD),
      enc_i(2, 21, F3_LH, 4, OP_LOAD),
      enc_i(32'hAA, 0, F3_ADD, 5, OP_IMM),
      enc_s(1, 5, 21, F3_SB),
      enc_i(0, 21, F3_LW, 6, OP_LOAD),
      enc_i(0, 21, F3_LHU, 7, OP_LOAD),
      enc_b(8, 3, 2, F3_BLT),
      enc_i(1, 0, F3_ADD, 8, OP_IMM)
    };
    load_prog();
    RST = 1'b0;

    run("lui_x20",  32'h04, 20, 32'h80FF_8000);
    run("addi_x20", 32'h08, 20, 32'h80FF_7F01);
    run("addi_x21", 32'h0C, 21, 32'h0000_0100);
    step();
    push("sw_addr", 0, 0, 32'h10);
    push("sw_mem", 2, 64, 32'h80FF_7F01);
    check_all();
    run("beq_taken",    32'h18, -1, 32'h0);
    run("jal_back",     32'h10, 1, 32'h0000_001C);
    run("beq_nottaken", 32'h14, -1, 32'h0);
    run("jalr_x1",      32'h1C, 0, 32'h0);
    run("lb_x2",        32'h20, 2, 32'hFFFF_FF80);
    run("lbu_x3",       32'h24, 3, 32'h0000_0080);
    run("lh_x4",        32'h28, 4, 32'hFFFF_80FF);
    run("addi_x5",      32'h2C, 5, 32'h0000_00AA);
    step();
    push("sb_addr", 0, 0, 32'h30);
    push("sb_mem", 2, 64, 32'h80FF_AA01);
    check_all();
    run("lw_x6",     32'h34, 6, 32'h80FF_AA01);
    run("lhu_x7",    32'h38, 7, 32'h0000_AA01);
    run("blt_taken", 32'h40, 8, 32'h0);

    RST = 1'b1;
    step();
    push("midreset_addr", 0, 0, 32'h0);
    push("midreset_x1", 1, 1, 32'h0);
    push("midreset_x6", 1, 6, 32'h0);
    push("midreset_x20", 1, 20, 32'h0);
    push("midreset_mem", 2, 64, 32'h80FF_AA01);
    check_all();
    RST = 1'b0;
    run("restart_lui", 32'h04, 20, 32'h80FF_8000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
